div_sequencer: RTL

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// Multi-cycle 32-bit divide/remainder sequencer (DIV, DIVU, REM, REMU) using
// restoring division on operand magnitudes, with early exit for divide-by-zero and signed overflow.
module div_sequencer (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        START,
  input  logic [4:0]  SELECT,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic        FLUSH,
  output logic        BUSY,
  output logic        STALL,
  output logic        VALID,
  output logic [31:0] RESULT
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q,  state_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic        first_q,  first_d;
  logic        isRem_q,  isRem_d;
  logic        negQ_q,   negQ_d;
  logic        negR_q,   negR_d;
  logic [31:0] dvd_q,    dvd_d;
  logic [31:0] dvs_q,    dvs_d;
  logic [31:0] rem_q,    rem_d;
  logic [31:0] result_q, result_d;

  logic        isDivOp;
  logic        isSigned;
  logic        opRem;
  logic        accept;
  logic        divZero;
  logic        overflow;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [32:0] remShift;
  logic [32:0] remSub;
  logic        qBit;
  logic [31:0] remNext;
  logic [31:0] quoNext;
  logic [31:0] finalQ;
  logic [31:0] finalR;

  assign isDivOp  = (SELECT[4:2] == 3'b011);
  assign isSigned = ~SELECT[0];
  assign opRem    = SELECT[1];
  assign accept   = (state_q == IDLE) & START & isDivOp & ~FLUSH;
  assign divZero  = (DATA2 == 32'd0);
  assign overflow = isSigned & (DATA1 == 32'h8000_0000) & (DATA2 == 32'hFFFF_FFFF);
  assign absA     = (isSigned & DATA1[31]) ? (~DATA1 + 32'd1) : DATA1;
  assign absB     = (isSigned & DATA2[31]) ? (~DATA2 + 32'd1) : DATA2;

  // One restoring step: the dividend register shifts out its MSB into the
  // 33-bit partial remainder and shifts the new quotient bit in at the bottom.
  assign remShift = {rem_q, dvd_q[31]};
  assign remSub   = remShift - {1'b0, dvs_q};
  assign qBit     = ~remSub[32];
  assign remNext  = qBit ? remSub[31:0] : remShift[31:0];
  assign quoNext  = {dvd_q[30:0], qBit};
  assign finalQ   = negQ_q ? (~quoNext + 32'd1) : quoNext;
  assign finalR   = negR_q ? (~remNext + 32'd1) : remNext;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    isRem_d  = isRem_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          isRem_d = opRem;
          negQ_d  = isSigned & (DATA1[31] ^ DATA2[31]);
          negR_d  = isSigned & DATA1[31];
          dvd_d   = absA;
          dvs_d   = absB;
          rem_d   = 32'd0;
          if (divZero) begin
            result_d = opRem ? DATA1 : 32'hFFFF_FFFF;
            state_d  = DONE;
          end else if (overflow) begin
            result_d = opRem ? 32'd0 : 32'h8000_0000;
            state_d  = DONE;
          end else begin
            cnt_d   = 5'd31;
            first_d = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // The first CALC cycle is an alignment bubble so the result lands on edge 33.
        if (first_q) begin
          first_d = 1'b0;
        end else begin
          dvd_d = quoNext;
          rem_d = remNext;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            result_d = isRem_q ? finalR : finalQ;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (FLUSH) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      first_q  <= 1'b0;
      isRem_q  <= 1'b0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      dvd_q    <= 32'd0;
      dvs_q    <= 32'd0;
      rem_q    <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      isRem_q  <= isRem_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign BUSY   = (state_q != IDLE);
  assign VALID  = (state_q == DONE);
  assign STALL  = (state_q == CALC) | accept;
  assign RESULT = result_q;

endmodule
